// File: rtl/mbus_tx_arbiter_pkg.sv
// Shared definitions for the MBus TX arbiter: MBus field widths and FSM state encoding.
// The field widths mirror mbus_def.v and are only defined here when not already provided.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mbus_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        XFER        = 3'd1,
        ACK_LOW     = 3'd2,
        WAIT_NEXT   = 3'd3,
        WAIT_RESULT = 3'd4,
        RESP        = 3'd5
    } tx_state_e;

    localparam int ADDR_W = `ADDR_WIDTH;
    localparam int DATA_W = `DATA_WIDTH;

endpackage

// File: rtl/mbus_rr_pick.sv
// Combinational round-robin picker: first set request bit after ptr, wrapping around.
module mbus_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan from farthest to nearest so the closest requester after ptr is the last write.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % NUM_REQ]) begin
                valid = 1'b1;
                idx   = IDX_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/mbus_tx_arbiter.sv
// Round-robin arbiter sharing one MBus TX port between NUM_REQ clients, grant held per message.
// Optional MBUS_TX_ARB_PRIO_EN restricts arbitration to prioritised requesters when any exist.
module mbus_tx_arbiter
    import mbus_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      CLKIN,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        REQ_TX_REQ,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_TX_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_TX_DATA,
    input  logic [NUM_REQ-1:0]        REQ_TX_PEND,
    input  logic [NUM_REQ-1:0]        REQ_PRIORITY,
    output logic [NUM_REQ-1:0]        REQ_TX_ACK,
    output logic [NUM_REQ-1:0]        REQ_DONE,
    output logic                      REQ_FAIL,
    output logic [ADDR_W-1:0]         TX_ADDR,
    output logic [DATA_W-1:0]         TX_DATA,
    output logic                      TX_REQ,
    output logic                      TX_PEND,
    output logic                      PRIORITY,
    input  logic                      TX_ACK,
    input  logic                      TX_SUCC,
    input  logic                      TX_FAIL,
    output logic                      TX_RESP_ACK
);

    tx_state_e          state;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   rr_ptr;
    logic               fail;

    logic [NUM_REQ-1:0] cand_req;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    always_comb begin
`ifdef MBUS_TX_ARB_PRIO_EN
        cand_req = ((REQ_TX_REQ & REQ_PRIORITY) != '0) ? (REQ_TX_REQ & REQ_PRIORITY) : REQ_TX_REQ;
`else
        cand_req = REQ_TX_REQ;
`endif
    end

    mbus_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (cand_req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Fields come from the new winner in IDLE, otherwise from the locked grant.
    assign sel_idx  = (state == IDLE) ? pick_idx : grant;
    assign sel_addr = REQ_TX_ADDR[int'(sel_idx)*ADDR_W +: ADDR_W];
    assign sel_data = REQ_TX_DATA[int'(sel_idx)*DATA_W +: DATA_W];

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= IDX_W'(NUM_REQ - 1);
            fail        <= 1'b0;
            REQ_TX_ACK  <= '0;
            REQ_DONE    <= '0;
            REQ_FAIL    <= 1'b0;
            TX_ADDR     <= '0;
            TX_DATA     <= '0;
            TX_REQ      <= 1'b0;
            TX_PEND     <= 1'b0;
            PRIORITY    <= 1'b0;
            TX_RESP_ACK <= 1'b0;
        end else begin
            REQ_DONE <= '0;
            // An abort from the wrapper ends the message wherever it is in transfer.
            if (TX_FAIL && (state == XFER || state == ACK_LOW || state == WAIT_NEXT)) begin
                TX_REQ      <= 1'b0;
                REQ_TX_ACK  <= '0;
                fail        <= 1'b1;
                TX_RESP_ACK <= 1'b1;
                state       <= RESP;
            end else begin
                case (state)
                    IDLE: begin
                        if (pick_valid) begin
                            grant    <= pick_idx;
                            TX_ADDR  <= sel_addr;
                            TX_DATA  <= sel_data;
                            TX_PEND  <= REQ_TX_PEND[sel_idx];
                            PRIORITY <= REQ_PRIORITY[sel_idx];
                            TX_REQ   <= 1'b1;
                            state    <= XFER;
                        end
                    end
                    XFER: begin
                        if (TX_ACK) begin
                            REQ_TX_ACK <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
                            TX_REQ     <= 1'b0;
                            state      <= ACK_LOW;
                        end
                    end
                    ACK_LOW: begin
                        if (!TX_ACK && !REQ_TX_REQ[grant]) begin
                            REQ_TX_ACK <= '0;
                            state      <= TX_PEND ? WAIT_NEXT : WAIT_RESULT;
                        end
                    end
                    WAIT_NEXT: begin
                        if (REQ_TX_REQ[grant]) begin
                            TX_ADDR  <= sel_addr;
                            TX_DATA  <= sel_data;
                            TX_PEND  <= REQ_TX_PEND[sel_idx];
                            PRIORITY <= REQ_PRIORITY[sel_idx];
                            TX_REQ   <= 1'b1;
                            state    <= XFER;
                        end
                    end
                    WAIT_RESULT: begin
                        if (TX_SUCC || TX_FAIL) begin
                            fail        <= TX_FAIL;
                            TX_RESP_ACK <= 1'b1;
                            state       <= RESP;
                        end
                    end
                    RESP: begin
                        if (!TX_SUCC && !TX_FAIL) begin
                            TX_RESP_ACK <= 1'b0;
                            REQ_DONE    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
                            REQ_FAIL    <= fail;
                            rr_ptr      <= grant;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mbus_tx_arbiter.sv
// Directed testbench for mbus_tx_arbiter: handshakes, round-robin, burst lock, failures, reset.
`timescale 1ns/1ps
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_mbus_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW = `ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;

    logic                    CLKIN = 1'b0;
    logic                    RESET = 1'b1;
    logic [NUM_REQ-1:0]      req, pend, prio;
    logic [AW-1:0]           c_addr [NUM_REQ];
    logic [DW-1:0]           c_data [NUM_REQ];
    logic [NUM_REQ*AW-1:0]   addr_bus;
    logic [NUM_REQ*DW-1:0]   data_bus;
    logic [NUM_REQ-1:0]      REQ_TX_ACK, REQ_DONE;
    logic                    REQ_FAIL, TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK;
    logic [AW-1:0]           TX_ADDR;
    logic [DW-1:0]           TX_DATA;
    logic                    TX_ACK, TX_SUCC, TX_FAIL;

    int checks = 0;
    int errors = 0;
    bit timed_out = 1'b0;

    logic [NUM_REQ-1:0] done_q[$];
    logic               fail_q[$];

    always #5 CLKIN = ~CLKIN;

    always_comb begin
        addr_bus = '0;
        data_bus = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_bus[i*AW +: AW] = c_addr[i];
            data_bus[i*DW +: DW] = c_data[i];
        end
    end

    mbus_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .CLKIN        (CLKIN),
        .RESET        (RESET),
        .REQ_TX_REQ   (req),
        .REQ_TX_ADDR  (addr_bus),
        .REQ_TX_DATA  (data_bus),
        .REQ_TX_PEND  (pend),
        .REQ_PRIORITY (prio),
        .REQ_TX_ACK   (REQ_TX_ACK),
        .REQ_DONE     (REQ_DONE),
        .REQ_FAIL     (REQ_FAIL),
        .TX_ADDR      (TX_ADDR),
        .TX_DATA      (TX_DATA),
        .TX_REQ       (TX_REQ),
        .TX_PEND      (TX_PEND),
        .PRIORITY     (PRIORITY),
        .TX_ACK       (TX_ACK),
        .TX_SUCC      (TX_SUCC),
        .TX_FAIL      (TX_FAIL),
        .TX_RESP_ACK  (TX_RESP_ACK)
    );

    always @(negedge CLKIN) begin
        if (REQ_DONE != '0) begin
            done_q.push_back(REQ_DONE);
            fail_q.push_back(REQ_FAIL);
        end
    end

    task automatic tick();
        @(posedge CLKIN);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        req = '0; pend = '0; prio = '0;
        TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        tick();
        done_q.delete();
        fail_q.delete();
    endtask

    // Wrapper side of one word: wait for TX_REQ, acknowledge, release the client.
    task automatic serve_word(output logic [AW-1:0] a, output logic [DW-1:0] d,
                              output logic p, output logic [NUM_REQ-1:0] ackv);
        int n;
        a = '0; d = '0; p = 1'b0; ackv = '0;
        n = 0;
        while (!TX_REQ && n < 30) begin tick(); n++; end
        if (!TX_REQ) begin timed_out = 1'b1; return; end
        a = TX_ADDR; d = TX_DATA; p = TX_PEND;
        TX_ACK = 1'b1;
        n = 0;
        do begin tick(); n++; end while (REQ_TX_ACK == '0 && n < 30);
        if (REQ_TX_ACK == '0) begin timed_out = 1'b1; TX_ACK = 1'b0; return; end
        ackv = REQ_TX_ACK;
        req = req & ~ackv;
        TX_ACK = 1'b0;
        tick();
    endtask

    task automatic serve_result(input logic s, input logic f);
        int n;
        TX_SUCC = s; TX_FAIL = f;
        n = 0;
        do begin tick(); n++; end while (!TX_RESP_ACK && n < 30);
        if (!TX_RESP_ACK) timed_out = 1'b1;
        TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick(); tick();
        checks++;
        if ({TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK, REQ_FAIL, REQ_TX_ACK, REQ_DONE, TX_ADDR, TX_DATA} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b ack=%b done=%b addr=%h data=%h exp all 0",
                     TX_REQ, REQ_TX_ACK, REQ_DONE, TX_ADDR, TX_DATA);
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        do_reset();
        c_addr[1] = 32'h12; c_data[1] = 32'hDEADBEEF; pend[1] = 1'b0; req[1] = 1'b1;
        tick();
        checks++;
        if (TX_REQ !== 1'b1 || TX_ADDR !== 32'h12 || TX_DATA !== 32'hDEADBEEF || TX_PEND !== 1'b0) begin
            errors++;
            $display("FAIL single_tx got req=%b addr=%h data=%h pend=%b exp 1 12 deadbeef 0",
                     TX_REQ, TX_ADDR, TX_DATA, TX_PEND);
        end
        TX_ACK = 1'b1;
        tick();
        checks++;
        if (REQ_TX_ACK !== 4'b0010 || TX_REQ !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got ack=%b txreq=%b exp 0010 0", REQ_TX_ACK, TX_REQ);
        end
        req[1] = 1'b0; TX_ACK = 1'b0;
        tick();
        checks++;
        if (REQ_TX_ACK !== 4'b0000) begin
            errors++;
            $display("FAIL single_ack_low got %b exp 0000", REQ_TX_ACK);
        end
        TX_SUCC = 1'b1;
        tick(); tick();
        checks++;
        if (TX_RESP_ACK !== 1'b1 || REQ_DONE !== 4'b0000) begin
            errors++;
            $display("FAIL single_resp got resp_ack=%b done=%b exp 1 0000", TX_RESP_ACK, REQ_DONE);
        end
        TX_SUCC = 1'b0;
        tick();
        checks++;
        if (TX_RESP_ACK !== 1'b0 || REQ_DONE !== 4'b0010 || REQ_FAIL !== 1'b0) begin
            errors++;
            $display("FAIL single_done got resp_ack=%b done=%b fail=%b exp 0 0010 0",
                     TX_RESP_ACK, REQ_DONE, REQ_FAIL);
        end
        tick();
        checks++;
        if (REQ_DONE !== 4'b0000 || done_q.size() != 1) begin
            errors++;
            $display("FAIL single_pulse got done=%b pulses=%0d exp 0000 1", REQ_DONE, done_q.size());
        end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] a; logic [DW-1:0] d; logic p; logic [NUM_REQ-1:0] ackv;
        logic [AW-1:0] exp_a [4] = '{32'hA0, 32'hA2, 32'hA3, 32'hA0};
        logic [NUM_REQ-1:0] exp_d [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            c_addr[i] = AW'(32'hA0 + i); c_data[i] = DW'(i);
        end
        req = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            serve_word(a, d, p, ackv);
            req = req | ackv;
            serve_result(1'b1, 1'b0);
            checks++;
            if (a !== exp_a[k]) begin
                errors++;
                $display("FAIL rr_grant%0d got %h exp %h", k, a, exp_a[k]);
            end
        end
        req = '0;
        tick(); tick();
        checks++;
        if (done_q.size() != 4) begin
            errors++;
            $display("FAIL rr_done_count got %0d exp 4", done_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (done_q[k] !== exp_d[k]) begin
                    errors++;
                    $display("FAIL rr_done%0d got %b exp %b", k, done_q[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_burst_lock();
        logic [AW-1:0] a; logic [DW-1:0] d; logic p; logic [NUM_REQ-1:0] ackv;
        logic [DW-1:0] words [3] = '{32'h10000001, 32'h10000002, 32'h10000003};
        logic          pends [3] = '{1'b1, 1'b1, 1'b0};
        do_reset();
        c_addr[0] = 32'h40; c_addr[3] = 32'h33; c_data[3] = 32'h3333; pend[3] = 1'b0;
        req = 4'b1001;
        for (int w = 0; w < 3; w++) begin
            c_data[0] = words[w]; pend[0] = pends[w]; req[0] = 1'b1;
            serve_word(a, d, p, ackv);
            checks++;
            if (a !== 32'h40 || d !== words[w] || p !== pends[w] || ackv !== 4'b0001) begin
                errors++;
                $display("FAIL burst_word%0d got addr=%h data=%h pend=%b ack=%b exp 40 %h %b 0001",
                         w, a, d, p, ackv, words[w], pends[w]);
            end
        end
        serve_result(1'b1, 1'b0);
        serve_word(a, d, p, ackv);
        checks++;
        if (a !== 32'h33 || ackv !== 4'b1000) begin
            errors++;
            $display("FAIL burst_next got addr=%h ack=%b exp 33 1000", a, ackv);
        end
        serve_result(1'b1, 1'b0);
        tick();
        checks++;
        if (done_q.size() != 2 || done_q[0] !== 4'b0001 || done_q[1] !== 4'b1000) begin
            errors++;
            $display("FAIL burst_done got count=%0d exp 2 pulses 0001 then 1000", done_q.size());
        end
    endtask

    task automatic test_mid_burst_fail();
        logic [AW-1:0] a; logic [DW-1:0] d; logic p; logic [NUM_REQ-1:0] ackv;
        do_reset();
        c_addr[2] = 32'h22; c_data[2] = 32'h2222; pend[2] = 1'b1; req = 4'b0100;
        serve_word(a, d, p, ackv);
        checks++;
        if (a !== 32'h22 || p !== 1'b1) begin
            errors++;
            $display("FAIL mf_first got addr=%h pend=%b exp 22 1", a, p);
        end
        c_addr[1] = 32'h11; c_data[1] = 32'h1111; pend[1] = 1'b0; req[1] = 1'b1;
        TX_FAIL = 1'b1;
        tick();
        checks++;
        if (TX_REQ !== 1'b0 || TX_RESP_ACK !== 1'b1 || REQ_TX_ACK !== 4'b0000) begin
            errors++;
            $display("FAIL mf_abort got txreq=%b resp_ack=%b ack=%b exp 0 1 0000",
                     TX_REQ, TX_RESP_ACK, REQ_TX_ACK);
        end
        TX_FAIL = 1'b0;
        tick();
        checks++;
        if (REQ_DONE !== 4'b0100 || REQ_FAIL !== 1'b1) begin
            errors++;
            $display("FAIL mf_done got done=%b fail=%b exp 0100 1", REQ_DONE, REQ_FAIL);
        end
        serve_word(a, d, p, ackv);
        checks++;
        if (a !== 32'h11 || ackv !== 4'b0010) begin
            errors++;
            $display("FAIL mf_next got addr=%h ack=%b exp 11 0010", a, ackv);
        end
        serve_result(1'b1, 1'b0);
        tick();
        checks++;
        if (done_q.size() != 2 || done_q[1] !== 4'b0010 || fail_q[1] !== 1'b0) begin
            errors++;
            $display("FAIL mf_next_done got count=%0d exp 2 with client1 success", done_q.size());
        end
    endtask

    task automatic test_succ_fail_same();
        logic [AW-1:0] a; logic [DW-1:0] d; logic p; logic [NUM_REQ-1:0] ackv;
        do_reset();
        c_addr[1] = 32'h15; c_data[1] = 32'h5; pend[1] = 1'b0; req = 4'b0010;
        serve_word(a, d, p, ackv);
        serve_result(1'b1, 1'b1);
        tick();
        checks++;
        if (done_q.size() != 1 || done_q[0] !== 4'b0010 || fail_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL both_result got count=%0d exp 1 pulse on client1 with fail=1", done_q.size());
        end
        tick(); tick();
        checks++;
        if (REQ_FAIL !== 1'b1) begin
            errors++;
            $display("FAIL fail_hold got %b exp 1", REQ_FAIL);
        end
        req = 4'b0010;
        serve_word(a, d, p, ackv);
        serve_result(1'b1, 1'b0);
        tick();
        checks++;
        if (REQ_FAIL !== 1'b0) begin
            errors++;
            $display("FAIL succ_after_fail got %b exp 0", REQ_FAIL);
        end
    endtask

    task automatic test_reset_mid_xfer();
        do_reset();
        c_addr[0] = 32'h77; c_data[0] = 32'h7777; pend[0] = 1'b0; req = 4'b0001;
        tick();
        checks++;
        if (TX_REQ !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got txreq=%b exp 1", TX_REQ);
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if ({TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK, REQ_FAIL, REQ_TX_ACK, REQ_DONE, TX_ADDR, TX_DATA} !== '0) begin
            errors++;
            $display("FAIL rst_async got txreq=%b addr=%h data=%h exp all 0", TX_REQ, TX_ADDR, TX_DATA);
        end
        req = '0;
        tick(); tick();
        RESET = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (done_q.size() != 0 || REQ_DONE !== 4'b0000 || TX_REQ !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done got pulses=%0d txreq=%b exp 0 0", done_q.size(), TX_REQ);
        end
    endtask

    task automatic test_priority();
        logic [AW-1:0] a; logic [DW-1:0] d; logic p; logic [NUM_REQ-1:0] ackv;
        logic [AW-1:0] exp_first, exp_second;
`ifdef MBUS_TX_ARB_PRIO_EN
        exp_first = 32'hB3; exp_second = 32'hB0;
`else
        exp_first = 32'hB0; exp_second = 32'hB3;
`endif
        do_reset();
        c_addr[0] = 32'hB0; c_addr[3] = 32'hB3; pend = '0; prio = 4'b1000; req = 4'b1001;
        serve_word(a, d, p, ackv);
        serve_result(1'b1, 1'b0);
        checks++;
        if (a !== exp_first) begin
            errors++;
            $display("FAIL prio_first got %h exp %h", a, exp_first);
        end
        serve_word(a, d, p, ackv);
        serve_result(1'b1, 1'b0);
        checks++;
        if (a !== exp_second) begin
            errors++;
            $display("FAIL prio_second got %h exp %h", a, exp_second);
        end
        prio = '0;
    endtask

    initial begin
        req = '0; pend = '0; prio = '0;
        TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c_addr[i] = '0; c_data[i] = '0;
        end
        test_reset();
        test_single_word();
        test_round_robin();
        test_burst_lock();
        test_mid_burst_fail();
        test_succ_fail_same();
        test_reset_mid_xfer();
        test_priority();
        checks++;
        if (timed_out !== 1'b0) begin
            errors++;
            $display("FAIL handshake_timeout got %b exp 0", timed_out);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
